// File: rtl/sgmii_smi_pkg.sv
// Shared Clause-22 frame layout, field widths and FSM encoding for the SGMII SMI master.
package sgmii_smi_pkg;

    localparam int PHY_ADDR_W = 5;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;

    localparam int PREAMBLE_LEN = 32;
    localparam int HEADER_LEN   = 14;
    localparam int TA_LEN       = 2;
    localparam int DATA_LEN     = 16;
    localparam int SHIFT_W      = HEADER_LEN + TA_LEN + DATA_LEN;
    localparam int BIT_CNT_W    = 5;

    localparam logic [1:0] ST_BITS  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_TA,
        S_DATA,
        S_DONE
    } smi_state_t;

    // Bit-counter reload value on entry to a state (bit periods in that state minus one).
    function automatic logic [BIT_CNT_W-1:0] state_bits(input smi_state_t s);
        case (s)
            S_PREAMBLE: return BIT_CNT_W'(PREAMBLE_LEN - 1);
            S_HEADER:   return BIT_CNT_W'(HEADER_LEN - 1);
            S_TA:       return BIT_CNT_W'(TA_LEN - 1);
            S_DATA:     return BIT_CNT_W'(DATA_LEN - 1);
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/sgmii_smi_clkgen.sv
// MDC generator: one bit period is 2*MDC_DIV cycles, low half first; counter parked at zero when disabled.
module sgmii_smi_clkgen #(
    parameter int MDC_DIV = 25
) (
    input  logic clk_125,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CNT_W = $clog2(2 * MDC_DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(MDC_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * MDC_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // rise_tick marks the first high cycle; fall_tick marks the last high cycle, so
    // anything updated on fall_tick appears on the first low cycle of the next bit.
    assign mdc       = en && (cnt >= HALF);
    assign rise_tick = en && (cnt == HALF);
    assign fall_tick = en && (cnt == LAST);

endmodule

// File: rtl/sgmii_smi_master.sv
// Clause-22 MDIO master for the SGMII core's SMI: one read or write frame per accepted request.
module sgmii_smi_master
    import sgmii_smi_pkg::*;
#(
    parameter int MDC_DIV = 25
) (
    input  logic                  clk_125,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [PHY_ADDR_W-1:0] req_phy_addr,
    input  logic [REG_ADDR_W-1:0] req_reg_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mdc,
    output logic                  mdout,
    output logic                  mdout_en,
    input  logic                  mdin
);

    smi_state_t           state, next_state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 clk_en, fall_tick, rise_tick, last_bit, accept;
    logic                 wr_q, ta_err;
    logic [SHIFT_W-1:0]   tx_sr;
    logic [DATA_W-1:0]    rx_sr;
    logic                 mdin_p0, mdin_p1;

    sgmii_smi_clkgen #(.MDC_DIV(MDC_DIV)) u_clkgen (
        .clk_125   (clk_125),
        .rst_n     (rst_n),
        .en        (clk_en),
        .mdc       (mdc),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    assign last_bit = fall_tick && (bit_cnt == '0);
    assign accept   = req_valid && (state == S_IDLE);

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (req_valid) next_state = S_PREAMBLE;
            S_PREAMBLE: if (last_bit)  next_state = S_HEADER;
            S_HEADER:   if (last_bit)  next_state = S_TA;
            S_TA:       if (last_bit)  next_state = S_DATA;
            S_DATA:     if (last_bit)  next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        clk_en    = 1'b0;
        mdout     = 1'b1;
        mdout_en  = 1'b0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_PREAMBLE: begin
                clk_en   = 1'b1;
                mdout_en = 1'b1;
            end
            S_HEADER: begin
                clk_en   = 1'b1;
                mdout    = tx_sr[SHIFT_W-1];
                mdout_en = 1'b1;
            end
            S_TA, S_DATA: begin
                clk_en   = 1'b1;
                mdout    = tx_sr[SHIFT_W-1];
                mdout_en = wr_q;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = wr_q ? '0 : rx_sr;
                rsp_err   = !wr_q && ta_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (next_state != state)
            bit_cnt <= state_bits(next_state);
        else if (fall_tick)
            bit_cnt <= bit_cnt - 1'b1;
    end

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            mdin_p0 <= 1'b0;
            mdin_p1 <= 1'b0;
        end else begin
            mdin_p0 <= mdin;
            mdin_p1 <= mdin_p0;
        end
    end

    // Reads load ones behind the address so the idle level sits on mdout while released.
    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            ta_err <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
        end else begin
            if (accept) begin
                wr_q   <= req_write;
                ta_err <= 1'b0;
                tx_sr  <= {ST_BITS, req_write ? OP_WRITE : OP_READ, req_phy_addr, req_reg_addr,
                           req_write ? TA_WRITE : 2'b11, req_write ? req_wdata : {DATA_W{1'b1}}};
            end else if (fall_tick && (state inside {S_HEADER, S_TA, S_DATA})) begin
                tx_sr <= {tx_sr[SHIFT_W-2:0], 1'b1};
            end
            if (rise_tick && state == S_TA && bit_cnt == '0)
                ta_err <= mdin_p1;
            if (rise_tick && state == S_DATA)
                rx_sr <= {rx_sr[DATA_W-2:0], mdin_p1};
        end
    end

endmodule
